// File: rtl/mesh_local_ni.sv
// Network interface for a mesh_router Local port: injection/ejection FIFOs, misroute filter, flush FSM.
// Optional traffic counters are enabled with `define NI_STATS_EN.

module mesh_local_ni_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wrPtr_q, rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush, doPop;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depthCheck
            $error("mesh_local_ni_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din_i;
    end
endmodule

module mesh_local_ni #(
    parameter int DATA_WIDTH = 32,
    parameter int X_WIDTH    = 4,
    parameter int Y_WIDTH    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int INJ_DEPTH  = 4,
    parameter int EJ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [X_WIDTH-1:0]    router_x,
    input  logic [Y_WIDTH-1:0]    router_y,
    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic [DATA_WIDTH-1:0] core_req_data,
    input  logic [X_WIDTH-1:0]    core_req_dst_x,
    input  logic [Y_WIDTH-1:0]    core_req_dst_y,
    output logic [DATA_WIDTH-1:0] inj_data,
    output logic [ADDR_WIDTH-1:0] inj_addr,
    output logic                  inj_valid,
    input  logic                  inj_ready,
    input  logic [DATA_WIDTH-1:0] ej_data,
    input  logic [ADDR_WIDTH-1:0] ej_addr,
    input  logic                  ej_valid,
    output logic                  ej_ready,
    output logic                  core_rsp_valid,
    input  logic                  core_rsp_ready,
    output logic [DATA_WIDTH-1:0] core_rsp_data,
    output logic [ADDR_WIDTH-1:0] core_rsp_src,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  misroute_err
`ifdef NI_STATS_EN
    ,
    output logic [15:0]           inj_cnt,
    output logic [15:0]           ej_cnt,
    output logic [15:0]           drop_cnt
`endif
);
    localparam int FW = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic            misroute_q;
    logic [FW-1:0]   injHead, ejHead;
    logic            injFull, injEmpty, ejFull, ejEmpty;
    logic            injPush, injPop, ejAccept, ejHit, ejPush, ejDrop, rspPop;
    logic [ADDR_WIDTH-1:0] ownAddr;

    generate
        if (ADDR_WIDTH != X_WIDTH + Y_WIDTH) begin : g_addrCheck
            $error("mesh_local_ni: ADDR_WIDTH must equal X_WIDTH + Y_WIDTH");
        end
    endgenerate

    assign ownAddr  = {router_y, router_x};
    assign injPush  = core_req_valid & core_req_ready;
    assign injPop   = inj_valid & inj_ready;
    assign ejAccept = ej_valid & ej_ready;
    assign ejHit    = (ej_addr == ownAddr);
    assign ejPush   = ejAccept & ejHit;
    assign ejDrop   = ejAccept & ~ejHit;
    assign rspPop   = core_rsp_valid & core_rsp_ready;

    mesh_local_ni_fifo #(.WIDTH(FW), .DEPTH(INJ_DEPTH)) u_injFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (injPush),
        .din_i   ({core_req_dst_y, core_req_dst_x, core_req_data}),
        .pop_i   (injPop),
        .dout_o  (injHead),
        .full_o  (injFull),
        .empty_o (injEmpty)
    );

    mesh_local_ni_fifo #(.WIDTH(FW), .DEPTH(EJ_DEPTH)) u_ejFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ejPush),
        .din_i   ({ej_addr, ej_data}),
        .pop_i   (rspPop),
        .dout_o  (ejHead),
        .full_o  (ejFull),
        .empty_o (ejEmpty)
    );

    assign inj_valid      = ~injEmpty;
    assign inj_addr       = injHead[FW-1:DATA_WIDTH];
    assign inj_data       = injHead[DATA_WIDTH-1:0];
    assign ej_ready       = ~ejFull;
    assign core_rsp_valid = ~ejEmpty;
    assign core_rsp_src   = ejHead[FW-1:DATA_WIDTH];
    assign core_rsp_data  = ejHead[DATA_WIDTH-1:0];
    assign misroute_err   = misroute_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            misroute_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (ejDrop) misroute_q <= 1'b1;
        end
    end

    // Flush blocks new requests until everything already queued has left toward the router.
    always_comb begin
        state_d        = state_q;
        core_req_ready = 1'b0;
        flush_done     = 1'b0;
        case (state_q)
            RUN: begin
                core_req_ready = ~injFull;
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (injEmpty) state_d = DONE;
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

`ifdef NI_STATS_EN
    logic [15:0] injCnt_q, ejCnt_q, dropCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            injCnt_q  <= '0;
            ejCnt_q   <= '0;
            dropCnt_q <= '0;
        end else begin
            if (injPop && injCnt_q != 16'hFFFF)  injCnt_q  <= injCnt_q + 16'd1;
            if (ejPush && ejCnt_q != 16'hFFFF)   ejCnt_q   <= ejCnt_q + 16'd1;
            if (ejDrop && dropCnt_q != 16'hFFFF) dropCnt_q <= dropCnt_q + 16'd1;
        end
    end

    assign inj_cnt  = injCnt_q;
    assign ej_cnt   = ejCnt_q;
    assign drop_cnt = dropCnt_q;
`endif
endmodule

// File: tb/tb_mesh_local_ni.sv
// Self-checking bench for mesh_local_ni: directed scenarios plus a randomized run against a queue-based model.
// Checks the traffic counters too when NI_STATS_EN is defined.

module tb_mesh_local_ni;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  router_x, router_y;
    logic        core_req_valid, core_req_ready;
    logic [31:0] core_req_data;
    logic [3:0]  core_req_dst_x, core_req_dst_y;
    logic [31:0] inj_data;
    logic [7:0]  inj_addr;
    logic        inj_valid, inj_ready;
    logic [31:0] ej_data;
    logic [7:0]  ej_addr;
    logic        ej_valid, ej_ready;
    logic        core_rsp_valid, core_rsp_ready;
    logic [31:0] core_rsp_data;
    logic [7:0]  core_rsp_src;
    logic        flush, flush_done, misroute_err;
`ifdef NI_STATS_EN
    logic [15:0] inj_cnt, ej_cnt, drop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: flits as {addr, data} in plain queues, flush as an abstract mode.
    typedef enum int {M_RUN, M_DRAIN, M_DONE} mode_t;
    logic [39:0] injQ[$];
    logic [39:0] ejQ[$];
    mode_t       mode = M_RUN;
    bit          misM = 1'b0;
    int          injCntM = 0, ejCntM = 0, dropCntM = 0;

    always #5 clk = ~clk;

    mesh_local_ni dut (
        .clk(clk), .rst(rst), .router_x(router_x), .router_y(router_y),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_data(core_req_data),
        .core_req_dst_x(core_req_dst_x), .core_req_dst_y(core_req_dst_y),
        .inj_data(inj_data), .inj_addr(inj_addr), .inj_valid(inj_valid), .inj_ready(inj_ready),
        .ej_data(ej_data), .ej_addr(ej_addr), .ej_valid(ej_valid), .ej_ready(ej_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_data(core_rsp_data), .core_rsp_src(core_rsp_src),
        .flush(flush), .flush_done(flush_done), .misroute_err(misroute_err)
`ifdef NI_STATS_EN
        , .inj_cnt(inj_cnt), .ej_cnt(ej_cnt), .drop_cnt(drop_cnt)
`endif
    );

    function automatic bit expReqReady();
        return (injQ.size() < DEPTH) && (mode == M_RUN);
    endfunction

    function automatic logic [39:0] expInjHead();
        return (injQ.size() > 0) ? injQ[0] : 40'h0;
    endfunction

    function automatic logic [39:0] expEjHead();
        return (ejQ.size() > 0) ? ejQ[0] : 40'h0;
    endfunction

    // Advance one clock: apply the handshake rules to the current stimulus, then settle 1 ns past the edge.
    task automatic cycle();
        bit reqRdy, injV, ejRdy, rspV, injWasEmpty;
        logic [39:0] dummy;
        reqRdy = expReqReady();
        injV   = injQ.size() > 0;
        ejRdy  = ejQ.size() < DEPTH;
        rspV   = ejQ.size() > 0;
        injWasEmpty = injQ.size() == 0;
        @(posedge clk);
        if (rst) begin
            injQ.delete(); ejQ.delete();
            mode = M_RUN; misM = 1'b0;
            injCntM = 0; ejCntM = 0; dropCntM = 0;
        end else begin
            if (injV && inj_ready) begin
                dummy = injQ.pop_front();
                if (injCntM < 65535) injCntM++;
            end
            if (core_req_valid && reqRdy) injQ.push_back({core_req_dst_y, core_req_dst_x, core_req_data});
            if (rspV && core_rsp_ready) dummy = ejQ.pop_front();
            if (ej_valid && ejRdy) begin
                if (ej_addr == {router_y, router_x}) begin
                    ejQ.push_back({ej_addr, ej_data});
                    if (ejCntM < 65535) ejCntM++;
                end else begin
                    misM = 1'b1;
                    if (dropCntM < 65535) dropCntM++;
                end
            end
            case (mode)
                M_RUN:   if (flush) mode = M_DRAIN;
                M_DRAIN: if (injWasEmpty) mode = M_DONE;
                default: mode = M_RUN;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        vectors++; if (inj_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_inj_valid: got %b expected 0", inj_valid); end
        vectors++; if (core_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", core_rsp_valid); end
        vectors++; if (core_req_ready !== 1'b1 || ej_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got req=%b ej=%b expected 1/1", core_req_ready, ej_ready); end
        vectors++; if (flush_done !== 1'b0 || misroute_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags: got done=%b mis=%b expected 0/0", flush_done, misroute_err); end
        vectors++; if ({inj_data, inj_addr, core_rsp_data, core_rsp_src} !== 80'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h/%h/%h/%h expected zeros", inj_data, inj_addr, core_rsp_data, core_rsp_src); end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_single_inject();
        inj_ready = 1'b1;
        core_req_valid = 1'b1; core_req_data = 32'hA5A5_0001; core_req_dst_x = 4'd3; core_req_dst_y = 4'd1;
        vectors++; if (core_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL single_req_ready: got %b expected 1", core_req_ready); end
        vectors++; if (inj_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pre_valid: got %b expected 0", inj_valid); end
        cycle();
        core_req_valid = 1'b0;
        vectors++; if (inj_valid !== 1'b1 || inj_addr !== 8'h13 || inj_data !== 32'hA5A5_0001) begin miscompares++; $display("[TB] FAIL single_flit: got v=%b addr=%h data=%h expected 1/13/a5a50001", inj_valid, inj_addr, inj_data); end
        cycle();
        vectors++; if (inj_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_one_flit: got %b expected 0", inj_valid); end
    endtask

    task automatic test_inj_backpressure();
        inj_ready = 1'b0;
        core_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            core_req_data = 32'h1000_0000 + i; core_req_dst_x = 4'(i); core_req_dst_y = 4'd3;
            vectors++; if (core_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_accept_%0d: got %b expected 1", i, core_req_ready); end
            cycle();
        end
        core_req_data = 32'hDEAD_BEEF;
        vectors++; if (core_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_full: got %b expected 0", core_req_ready); end
        cycle();
        core_req_valid = 1'b0;
        inj_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (inj_valid !== 1'b1 || inj_data !== 32'h1000_0000 + i || inj_addr !== {4'd3, 4'(i)}) begin miscompares++; $display("[TB] FAIL bp_order_%0d: got v=%b addr=%h data=%h expected 1/%h/%h", i, inj_valid, inj_addr, inj_data, {4'd3, 4'(i)}, 32'h1000_0000 + i); end
            cycle();
        end
        vectors++; if (inj_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_drained: got %b expected 0", inj_valid); end
    endtask

    task automatic test_ejection();
        core_rsp_ready = 1'b0;
        ej_valid = 1'b1; ej_addr = 8'h21; ej_data = 32'h3C3C_0021;
        cycle();
        ej_valid = 1'b0;
        vectors++; if (core_rsp_valid !== 1'b1 || core_rsp_data !== 32'h3C3C_0021 || core_rsp_src !== 8'h21) begin miscompares++; $display("[TB] FAIL ej_deliver: got v=%b data=%h src=%h expected 1/3c3c0021/21", core_rsp_valid, core_rsp_data, core_rsp_src); end
        vectors++; if (misroute_err !== 1'b0) begin miscompares++; $display("[TB] FAIL ej_no_misroute: got %b expected 0", misroute_err); end
        core_rsp_ready = 1'b1;
        cycle();
        ej_valid = 1'b1; ej_addr = 8'h22; ej_data = 32'hBAD0_0022;
        cycle();
        ej_valid = 1'b0;
        vectors++; if (misroute_err !== 1'b1 || core_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ej_drop: got mis=%b v=%b expected 1/0", misroute_err, core_rsp_valid); end
    endtask

    task automatic test_ej_backpressure();
        core_rsp_ready = 1'b0;
        ej_valid = 1'b1; ej_addr = 8'h21;
        for (int i = 0; i < 4; i++) begin
            ej_data = 32'h5000_0000 + i;
            cycle();
        end
        ej_data = 32'h5000_0004;
        vectors++; if (ej_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ejbp_full: got %b expected 0", ej_ready); end
        cycle();
        core_rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                vectors++; if (ej_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ejbp_reopen: got %b expected 1", ej_ready); end
            end
            if (k == 2) ej_valid = 1'b0;
            vectors++; if (core_rsp_valid !== 1'b1 || core_rsp_data !== 32'h5000_0000 + k) begin miscompares++; $display("[TB] FAIL ejbp_order_%0d: got v=%b data=%h expected 1/%h", k, core_rsp_valid, core_rsp_data, 32'h5000_0000 + k); end
            cycle();
        end
        vectors++; if (core_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ejbp_empty: got %b expected 0", core_rsp_valid); end
    endtask

    task automatic test_flush();
        inj_ready = 1'b0;
        core_req_valid = 1'b1; core_req_dst_x = 4'd5; core_req_dst_y = 4'd6;
        core_req_data = 32'hF000_0001; cycle();
        core_req_data = 32'hF000_0002; cycle();
        core_req_valid = 1'b0;
        flush = 1'b1; cycle(); flush = 1'b0;
        vectors++; if (core_req_ready !== 1'b0 || flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drain: got ready=%b done=%b expected 0/0", core_req_ready, flush_done); end
        inj_ready = 1'b1;
        cycle();
        cycle();
        vectors++; if (inj_valid !== 1'b0 || flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_last: got v=%b done=%b expected 0/0", inj_valid, flush_done); end
        cycle();
        vectors++; if (flush_done !== 1'b1 || core_req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_pulse: got done=%b ready=%b expected 1/0", flush_done, core_req_ready); end
        cycle();
        vectors++; if (flush_done !== 1'b0 || core_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_return: got done=%b ready=%b expected 0/1", flush_done, core_req_ready); end
        flush = 1'b1; cycle(); flush = 1'b0;
        cycle();
        vectors++; if (flush_done !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_empty: got %b expected 1", flush_done); end
        cycle();
    endtask

    task automatic test_random();
        logic [39:0] injH, ejH;
        for (int n = 0; n < 400; n++) begin
            core_req_valid = ($urandom_range(0, 2) != 0);
            core_req_data  = $urandom();
            core_req_dst_x = 4'($urandom());
            core_req_dst_y = 4'($urandom());
            inj_ready      = ($urandom_range(0, 2) != 0);
            ej_valid       = ($urandom_range(0, 1) != 0);
            ej_data        = $urandom();
            ej_addr        = ($urandom_range(0, 3) != 0) ? {router_y, router_x} : 8'($urandom());
            core_rsp_ready = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 19) == 0);
            injH = expInjHead();
            ejH  = expEjHead();
            vectors++; if (core_req_ready !== expReqReady()) begin miscompares++; $display("[TB] FAIL rnd_req_ready @%0d: got %b expected %b", n, core_req_ready, expReqReady()); end
            vectors++; if (inj_valid !== (injQ.size() > 0) || {inj_addr, inj_data} !== injH) begin miscompares++; $display("[TB] FAIL rnd_inj @%0d: got v=%b %h%h expected v=%b %h", n, inj_valid, inj_addr, inj_data, injQ.size() > 0, injH); end
            vectors++; if (ej_ready !== (ejQ.size() < DEPTH)) begin miscompares++; $display("[TB] FAIL rnd_ej_ready @%0d: got %b expected %b", n, ej_ready, ejQ.size() < DEPTH); end
            vectors++; if (core_rsp_valid !== (ejQ.size() > 0) || {core_rsp_src, core_rsp_data} !== ejH) begin miscompares++; $display("[TB] FAIL rnd_rsp @%0d: got v=%b %h%h expected v=%b %h", n, core_rsp_valid, core_rsp_src, core_rsp_data, ejQ.size() > 0, ejH); end
            vectors++; if (flush_done !== (mode == M_DONE) || misroute_err !== misM) begin miscompares++; $display("[TB] FAIL rnd_flags @%0d: got done=%b mis=%b expected %b/%b", n, flush_done, misroute_err, mode == M_DONE, misM); end
`ifdef NI_STATS_EN
            vectors++; if (inj_cnt !== 16'(injCntM) || ej_cnt !== 16'(ejCntM) || drop_cnt !== 16'(dropCntM)) begin miscompares++; $display("[TB] FAIL rnd_counters @%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, inj_cnt, ej_cnt, drop_cnt, injCntM, ejCntM, dropCntM); end
`endif
            cycle();
        end
        flush = 1'b0; core_req_valid = 1'b0; ej_valid = 1'b0;
    endtask

    task automatic test_reset_midtraffic();
        inj_ready = 1'b0; core_rsp_ready = 1'b0;
        core_req_valid = 1'b1;
        core_req_data = 32'h7700_0001; cycle();
        core_req_data = 32'h7700_0002; cycle();
        core_req_valid = 1'b0;
        ej_valid = 1'b1; ej_addr = 8'h21;
        ej_data = 32'h8800_0001; cycle();
        ej_data = 32'h8800_0002; cycle();
        ej_addr = 8'h45; cycle();
        ej_valid = 1'b0;
        vectors++; if (inj_valid !== 1'b1 || core_rsp_valid !== 1'b1 || misroute_err !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_setup: got inj=%b rsp=%b mis=%b expected 1/1/1", inj_valid, core_rsp_valid, misroute_err); end
        rst = 1'b1;
        cycle();
        vectors++; if (inj_valid !== 1'b0 || core_rsp_valid !== 1'b0 || misroute_err !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_clear: got inj=%b rsp=%b mis=%b expected 0/0/0", inj_valid, core_rsp_valid, misroute_err); end
`ifdef NI_STATS_EN
        vectors++; if (inj_cnt !== 16'h0 || ej_cnt !== 16'h0 || drop_cnt !== 16'h0) begin miscompares++; $display("[TB] FAIL midrst_counters: got %0d/%0d/%0d expected 0/0/0", inj_cnt, ej_cnt, drop_cnt); end
`endif
        rst = 1'b0;
        inj_ready = 1'b1; core_rsp_ready = 1'b1;
        cycle();
        vectors++; if (inj_valid !== 1'b0 || core_req_ready !== 1'b1 || ej_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_after: got inj=%b req=%b ej=%b expected 0/1/1", inj_valid, core_req_ready, ej_ready); end
    endtask

    initial begin
        rst = 1'b1; router_x = 4'd1; router_y = 4'd2;
        core_req_valid = 1'b0; core_req_data = '0; core_req_dst_x = '0; core_req_dst_y = '0;
        inj_ready = 1'b0; ej_valid = 1'b0; ej_addr = '0; ej_data = '0;
        core_rsp_ready = 1'b0; flush = 1'b0;
        #1;
        test_reset();
        test_single_inject();
        test_inj_backpressure();
        test_ejection();
        test_ej_backpressure();
        test_flush();
        test_random();
        test_reset_midtraffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
